// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared types and constants for the AER SRAM FIFO controller
package aer_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CW    = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/sram_fifo_obuf.sv
// rtl/sram_fifo_obuf.sv - 2-entry registered output buffer fed by the SRAM read port
module sram_fifo_obuf
  import aer_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [DWIDTH-1:0]  push_data,
  input  logic               pop,
  output logic [DWIDTH-1:0]  head,
  output logic [OBUF_CW-1:0] count
);

  logic [DWIDTH-1:0]  ent0_q, ent0_d;
  logic [DWIDTH-1:0]  ent1_q, ent1_d;
  logic [OBUF_CW-1:0] cnt_q, cnt_d;

  // A pop on an empty buffer is ignored; a push into a full buffer only lands alongside a pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (clr) begin
      ent0_d = '0;
      ent1_d = '0;
      cnt_d  = '0;
    end else begin
      case (cnt_q)
        OBUF_CW'(0): begin
          if (push) begin
            ent0_d = push_data;
            cnt_d  = OBUF_CW'(1);
          end
        end
        OBUF_CW'(1): begin
          if (push && pop) begin
            ent0_d = push_data;
          end else if (push) begin
            ent1_d = push_data;
            cnt_d  = OBUF_CW'(2);
          end else if (pop) begin
            cnt_d  = OBUF_CW'(0);
          end
        end
        default: begin
          if (pop) begin
            ent0_d = ent1_q;
            if (push) ent1_d = push_data;
            else      cnt_d  = OBUF_CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl_v2.sv
// rtl/sram_fifo_ctrl_v2.sv - dual-port SRAM FIFO controller with prefetch output buffer
module sram_fifo_ctrl_v2
  import aer_pkg::*;
#(
  parameter  int DWIDTH = 16,
  parameter  int DEPTH  = 16,
  parameter  int FWFT   = 1,
  localparam int AWIDTH = $clog2(DEPTH),
  localparam int WMASK  = DWIDTH / 8,
  localparam int CWIDTH = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rst_n,
  input  logic              fifo_wr_en,
  input  logic [DWIDTH-1:0] fifo_wdata,
  input  logic              fifo_rd_en,
  output logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rvalid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CWIDTH-1:0] fifo_numel,
  input  logic [CWIDTH-1:0] afull_thresh,
  input  logic [CWIDTH-1:0] aempty_thresh,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic              ovf_sticky,
  output logic              udf_sticky,
  output logic              ce_a,
  output logic              we_a,
  output logic [AWIDTH-1:0] addr_a,
  output logic [WMASK-1:0]  wmask_a,
  output logic [DWIDTH-1:0] wdata_a,
  input  logic [DWIDTH-1:0] rdata_a,
  output logic              ce_b,
  output logic              we_b,
  output logic [AWIDTH-1:0] addr_b,
  output logic [WMASK-1:0]  wmask_b,
  output logic [DWIDTH-1:0] wdata_b,
  input  logic [DWIDTH-1:0] rdata_b
);

  localparam fifo_mode_e        MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CWIDTH-1:0] NUMEL_MAX = CWIDTH'(DEPTH + OBUF_DEPTH);

  logic [AWIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]    sram_cnt_q, sram_cnt_d;
  logic               inflight_q, inflight_d;
  logic [CWIDTH-1:0]  numel_q, numel_d;
  logic               afull_q, afull_d, aempty_q, aempty_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic               acc_wr, acc_rd, issue;
  logic [DWIDTH-1:0]  obuf_head;
  logic [OBUF_CW-1:0] obuf_cnt;
  logic               unused_rdata_a;

  assign fifo_full  = (numel_q == NUMEL_MAX);
  assign fifo_empty = (obuf_cnt == '0);
  assign acc_wr     = fifo_rst_n && fifo_wr_en && !fifo_full;
  assign acc_rd     = fifo_rst_n && fifo_rd_en && !fifo_empty;
  // Issue only when the buffer can take the word even if nobody pops, so ce_b never looks at fifo_rd_en.
  assign issue      = fifo_rst_n && (sram_cnt_q != '0) &&
                      ((3'(obuf_cnt) + 3'(inflight_q)) < 3'(OBUF_DEPTH));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    inflight_d = 1'b0;
    numel_d    = numel_q;
    afull_d    = afull_q;
    aempty_d   = aempty_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (!fifo_rst_n) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sram_cnt_d = '0;
      numel_d    = '0;
      afull_d    = 1'b0;
      aempty_d   = 1'b1;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + AWIDTH'(acc_wr);
      rd_ptr_d   = rd_ptr_q + AWIDTH'(issue);
      sram_cnt_d = sram_cnt_q + (AWIDTH+1)'(acc_wr) - (AWIDTH+1)'(issue);
      inflight_d = issue;
      numel_d    = numel_q + CWIDTH'(acc_wr) - CWIDTH'(acc_rd);
      afull_d    = (numel_d >= afull_thresh);
      aempty_d   = (numel_d <= aempty_thresh);
      ovf_d      = ovf_q | (fifo_wr_en && fifo_full);
      udf_d      = udf_q | (fifo_rd_en && fifo_empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      numel_q    <= '0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      numel_q    <= numel_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  sram_fifo_obuf #(.DWIDTH(DWIDTH)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!fifo_rst_n),
    .push      (inflight_q),
    .push_data (rdata_b),
    .pop       (acc_rd),
    .head      (obuf_head),
    .count     (obuf_cnt)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign fifo_rdata  = obuf_head;
      assign fifo_rvalid = !fifo_empty;
    end else begin : g_std
      logic [DWIDTH-1:0] rdata_q, rdata_d;
      logic              rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (!fifo_rst_n) begin
          rdata_d = '0;
        end else if (acc_rd) begin
          rdata_d  = obuf_head;
          rvalid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign fifo_rdata  = rdata_q;
      assign fifo_rvalid = rvalid_q;
    end
  endgenerate

  assign fifo_numel     = numel_q;
  assign fifo_afull     = afull_q;
  assign fifo_aempty    = aempty_q;
  assign ovf_sticky     = ovf_q;
  assign udf_sticky     = udf_q;
  assign ce_a           = acc_wr;
  assign we_a           = acc_wr;
  assign addr_a         = wr_ptr_q;
  assign wmask_a        = {WMASK{acc_wr}};
  assign wdata_a        = fifo_wdata;
  assign ce_b           = issue;
  assign we_b           = 1'b0;
  assign addr_b         = rd_ptr_q;
  assign wmask_b        = '0;
  assign wdata_b        = '0;
  assign unused_rdata_a = ^rdata_a;

endmodule

// File: tb/tb_sram_fifo_ctrl_v2.sv
// tb/tb_sram_fifo_ctrl_v2.sv - queue-model bench driving FWFT and standard-mode controllers in lockstep
module tb_sram_fifo_ctrl_v2;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;
  localparam int WM    = 2;

  logic          clk = 1'b0;
  logic          rst_n, fifo_rst_n, wr_en, rd_en;
  logic [DW-1:0] wdata;
  logic [CW-1:0] afull_thr, aempty_thr;

  logic [DW-1:0] rdata1, wdata_a1, wdata_b1, rdb1;
  logic [DW-1:0] rdata0, wdata_a0, wdata_b0, rdb0;
  logic          rvalid1, empty1, full1, afull1, aempty1, ovf1, udf1, ce_a1, we_a1, ce_b1, we_b1;
  logic          rvalid0, empty0, full0, afull0, aempty0, ovf0, udf0, ce_a0, we_a0, ce_b0, we_b0;
  logic [CW-1:0] numel1, numel0;
  logic [AW-1:0] addr_a1, addr_b1, addr_a0, addr_b0;
  logic [WM-1:0] wmask_a1, wmask_b1, wmask_a0, wmask_b0;
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem0 [DEPTH];

  always #5 clk = ~clk;

  sram_fifo_ctrl_v2 #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_rst_n(fifo_rst_n), .fifo_wr_en(wr_en), .fifo_wdata(wdata),
    .fifo_rd_en(rd_en), .fifo_rdata(rdata1), .fifo_rvalid(rvalid1), .fifo_empty(empty1),
    .fifo_full(full1), .fifo_numel(numel1), .afull_thresh(afull_thr), .aempty_thresh(aempty_thr),
    .fifo_afull(afull1), .fifo_aempty(aempty1), .ovf_sticky(ovf1), .udf_sticky(udf1),
    .ce_a(ce_a1), .we_a(we_a1), .addr_a(addr_a1), .wmask_a(wmask_a1), .wdata_a(wdata_a1),
    .rdata_a('0), .ce_b(ce_b1), .we_b(we_b1), .addr_b(addr_b1), .wmask_b(wmask_b1),
    .wdata_b(wdata_b1), .rdata_b(rdb1)
  );

  sram_fifo_ctrl_v2 #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_rst_n(fifo_rst_n), .fifo_wr_en(wr_en), .fifo_wdata(wdata),
    .fifo_rd_en(rd_en), .fifo_rdata(rdata0), .fifo_rvalid(rvalid0), .fifo_empty(empty0),
    .fifo_full(full0), .fifo_numel(numel0), .afull_thresh(afull_thr), .aempty_thresh(aempty_thr),
    .fifo_afull(afull0), .fifo_aempty(aempty0), .ovf_sticky(ovf0), .udf_sticky(udf0),
    .ce_a(ce_a0), .we_a(we_a0), .addr_a(addr_a0), .wmask_a(wmask_a0), .wdata_a(wdata_a0),
    .rdata_a('0), .ce_b(ce_b0), .we_b(we_b0), .addr_b(addr_b0), .wmask_b(wmask_b0),
    .wdata_b(wdata_b0), .rdata_b(rdb0)
  );

  // 1-cycle read-before-write dual-port SRAMs
  always @(posedge clk) begin
    if (ce_a1 && we_a1) mem1[addr_a1] <= wdata_a1;
    if (ce_b1) rdb1 <= mem1[addr_b1];
    if (ce_a0 && we_a0) mem0[addr_a0] <= wdata_a0;
    if (ce_b0) rdb0 <= mem0[addr_b0];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words in the SRAM, words in the read pipe, words visible to the reader.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] pq[$];
  logic [DW-1:0] oq[$];
  bit            m_ovf, m_udf, m_afull, m_aempty, m_rv0;
  logic [DW-1:0] m_rd0;
  int            m_wrp, m_rdp;

  function automatic void m_reset();
    mq.delete(); pq.delete(); oq.delete();
    m_ovf = 0; m_udf = 0; m_afull = 0; m_aempty = 1; m_rv0 = 0;
    m_rd0 = '0; m_wrp = 0; m_rdp = 0;
  endfunction

  initial m_reset();

  always @(negedge clk) begin : cmp
    int total;
    bit full, empty, issue, acc_wr, acc_rd;
    total  = mq.size() + pq.size() + oq.size();
    full   = (total == DEPTH + 2);
    empty  = (oq.size() == 0);
    issue  = fifo_rst_n && (mq.size() != 0) && (oq.size() + pq.size() < 2);
    acc_wr = fifo_rst_n && wr_en && !full;
    acc_rd = fifo_rst_n && rd_en && !empty;

    chk("empty1", empty1, empty);
    chk("empty0", empty0, empty);
    chk("full1", full1, full);
    chk("numel1", numel1, total);
    chk("numel0", numel0, total);
    chk("afull1", afull1, m_afull);
    chk("aempty1", aempty1, m_aempty);
    chk("aempty0", aempty0, m_aempty);
    chk("ovf1", ovf1, m_ovf);
    chk("udf0", udf0, m_udf);
    chk("ce_a1", ce_a1, acc_wr);
    chk("ce_b1", ce_b1, issue);
    chk("ce_b0", ce_b0, issue);
    if (acc_wr) chk("addr_a1", addr_a1, m_wrp % DEPTH);
    if (issue)  chk("addr_b1", addr_b1, m_rdp % DEPTH);
    chk("rvalid1", rvalid1, !empty);
    if (!empty) chk("rdata1", rdata1, oq[0]);
    chk("rvalid0", rvalid0, m_rv0);
    chk("rdata0", rdata0, m_rd0);

    if (!rst_n || !fifo_rst_n) begin
      m_reset();
    end else begin
      m_ovf = m_ovf | (wr_en && full);
      m_udf = m_udf | (rd_en && empty);
      m_rv0 = acc_rd;
      if (acc_rd) m_rd0 = oq.pop_front();
      if (pq.size() != 0) oq.push_back(pq.pop_front());
      if (issue) begin
        pq.push_back(mq.pop_front());
        m_rdp++;
      end
      if (acc_wr) begin
        mq.push_back(wdata);
        m_wrp++;
      end
      total    = mq.size() + pq.size() + oq.size();
      m_afull  = (total >= int'(afull_thr));
      m_aempty = (total <= int'(aempty_thr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic soft_reset();
    fifo_rst_n = 1'b0;
    step();
    fifo_rst_n = 1'b1;
  endtask

  task automatic wait_nonempty(input string name);
    int k = 0;
    while (empty1 && k < 20) begin
      step();
      k++;
    end
    chk(name, empty1, 1'b0);
  endtask

  initial begin
    int k;
    rst_n = 1'b1; fifo_rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    afull_thr = CW'(15); aempty_thr = CW'(2);
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_empty", empty1, 1'b1);
    chk("rst_aempty", aempty1, 1'b1);
    chk("rst_full", full1, 1'b0);
    chk("rst_numel", numel1, 0);
    chk("rst_rdata1", rdata1, 16'h0000);
    chk("rst_rdata0", rdata0, 16'h0000);
    chk("rst_rvalid0", rvalid0, 1'b0);

    // single word latency in FWFT mode
    wr_en = 1'b1; wdata = 16'hA5A5;
    step();
    wr_en = 1'b0;
    k = 1;
    while (empty1 && k < 10) begin
      step();
      k++;
    end
    chk("fwft_latency", k, 3);
    chk("fwft_rdata", rdata1, 16'hA5A5);
    chk("fwft_numel", numel1, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;

    // fill to 18, overflow attempt, ordered drain
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wdata = DW'(i);
      step();
    end
    wr_en = 1'b0;
    chk("fill_full", full1, 1'b1);
    chk("fill_numel", numel1, 18);
    wr_en = 1'b1; wdata = 16'h0099;
    step();
    wr_en = 1'b0;
    chk("ovf_set", ovf1, 1'b1);
    chk("ovf_numel", numel1, 18);
    for (int i = 0; i < 18; i++) begin
      wait_nonempty("drain_wait");
      chk("drain_data", rdata1, DW'(i));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    chk("drain_empty", empty1, 1'b1);
    soft_reset();
    chk("srst_ovf", ovf1, 1'b0);

    // standard mode read and underflow
    wr_en = 1'b1; wdata = 16'h1234;
    step();
    wr_en = 1'b0;
    wait_nonempty("std_wait");
    chk("std_rvalid_idle", rvalid0, 1'b0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("std_rvalid", rvalid0, 1'b1);
    chk("std_rdata", rdata0, 16'h1234);
    step();
    chk("std_rvalid_drop", rvalid0, 1'b0);
    chk("std_rdata_hold", rdata0, 16'h1234);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("udf_set", udf0, 1'b1);
    chk("udf_rdata_hold", rdata0, 16'h1234);
    soft_reset();

    // almost-full / almost-empty thresholds
    for (int n = 1; n <= 15; n++) begin
      wr_en = 1'b1; wdata = DW'(16'h0400 + n);
      step();
      wr_en = 1'b0;
      chk("thr_afull", afull1, (n >= 15));
      chk("thr_aempty", aempty1, (n <= 2));
    end
    wait_nonempty("thr_wait");
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("thr_numel14", numel1, 14);
    chk("thr_afull_drop", afull1, 1'b0);
    soft_reset();

    // soft reset with a read in flight
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wdata = DW'(16'h0300 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (3) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("srst_ce_b", ce_b1, 1'b1);
    step();
    soft_reset();
    chk("srst_numel", numel1, 0);
    chk("srst_empty", empty1, 1'b1);
    wr_en = 1'b1; wdata = 16'hBEEF;
    step();
    wr_en = 1'b0;
    wait_nonempty("srst_wait");
    chk("srst_rdata", rdata1, 16'hBEEF);
    chk("srst_numel1", numel1, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("srst_rdata0", rdata0, 16'hBEEF);

    // streaming after a 4-word preload
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wdata = DW'(16'h0100 + i);
      step();
    end
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = DW'(16'h0200 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    soft_reset();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) begin
        afull_thr  = CW'($urandom_range(0, 18));
        aempty_thr = CW'($urandom_range(0, 18));
      end
      wr_en      = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd_en      = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      wdata      = DW'($urandom);
      fifo_rst_n = ($urandom_range(0, 127) != 0);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; fifo_rst_n = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
